// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load extraction, write-data select and retire counter.
module mem_wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_regwrite,
    input  logic [4:0]  m_a3,
    input  logic [1:0]  m_wdsel,
    input  logic [31:0] m_alu_result,
    input  logic [31:0] m_mem_rdata,
    input  logic [2:0]  m_load_type,
    output logic        w_regwrite,
    output logic [4:0]  w_a3,
    output logic [31:0] w_wd,
    output logic [31:0] w_pc,
    output logic        w_valid,
    output logic [31:0] w_retired
);
    logic        valid_q, valid_d, regwrite_q, regwrite_d;
    logic [4:0]  a3_q, a3_d;
    logic [31:0] wd_q, wd_d, pc_q, pc_d, retired_q, retired_d;
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] load_data, sel_data;

    always_comb begin
        half = m_alu_result[1] ? m_mem_rdata[31:16] : m_mem_rdata[15:0];
        byte_v = m_alu_result[1] ? (m_alu_result[0] ? m_mem_rdata[31:24] : m_mem_rdata[23:16])
                                 : (m_alu_result[0] ? m_mem_rdata[15:8] : m_mem_rdata[7:0]);
        load_data = m_load_type == 3'd1 ? {{16{half[15]}}, half} :
                    m_load_type == 3'd2 ? {16'b0, half} :
                    m_load_type == 3'd3 ? {{24{byte_v[7]}}, byte_v} :
                    m_load_type == 3'd4 ? {24'b0, byte_v} : m_mem_rdata;
        sel_data = m_wdsel == 2'd0 ? m_alu_result :
                   m_wdsel == 2'd1 ? load_data :
                   m_wdsel == 2'd2 ? m_pc + 32'd8 : 32'd0;
        valid_d = valid_q;
        regwrite_d = regwrite_q;
        a3_d = a3_q;
        wd_d = wd_q;
        pc_d = pc_q;
        retired_d = reset ? 32'd0 : retired_q;
        // A bubble is loaded on reset, flush, or a capture of an empty M stage
        if (reset || flush || (!stall && !m_valid)) begin
            valid_d = 1'b0;
            regwrite_d = 1'b0;
            a3_d = 5'd0;
            wd_d = 32'd0;
            pc_d = RESET_PC;
        end else if (!stall) begin
            valid_d = 1'b1;
            regwrite_d = m_regwrite && (m_a3 != 5'd0);
            a3_d = m_a3;
            wd_d = sel_data;
            pc_d = m_pc;
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        regwrite_q <= regwrite_d;
        a3_q <= a3_d;
        wd_q <= wd_d;
        pc_q <= pc_d;
        retired_q <= retired_d;
    end

    assign w_valid = valid_q;
    assign w_regwrite = regwrite_q;
    assign w_a3 = a3_q;
    assign w_wd = wd_q;
    assign w_pc = pc_q;
    assign w_retired = retired_q;
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, giving the w_pc value for a bubble.
REQ-002 The block SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port stall, input, 1 bit, which holds the W-stage register.
REQ-005 The block SHALL have port flush, input, 1 bit, which loads a bubble into the W stage.
REQ-006 The block SHALL have port m_valid, input, 1 bit, meaning the M stage holds a real instruction.
REQ-007 The block SHALL have port m_pc, input, 32 bits, the PC of the M-stage instruction.
REQ-008 The block SHALL have port m_regwrite, input, 1 bit, meaning the instruction writes the GPR file.
REQ-009 The block SHALL have port m_a3, input, 5 bits, the destination register number.
REQ-010 The block SHALL have port m_wdsel, input, 2 bits, the write-data source: 0 ALU, 1 load, 2 PC+8, 3 reserved.
REQ-011 The block SHALL have port m_alu_result, input, 32 bits, the ALU result, which is also the load address.
REQ-012 The block SHALL have port m_mem_rdata, input, 32 bits, the raw data word from data memory.
REQ-013 The block SHALL have port m_load_type, input, 3 bits: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU.
REQ-014 The block SHALL have port w_regwrite, output, 1 bit, the GPR write enable.
REQ-015 The block SHALL have port w_a3, output, 5 bits, the GPR write address.
REQ-016 The block SHALL have port w_wd, output, 32 bits, the GPR write data.
REQ-017 The block SHALL have port w_pc, output, 32 bits, the PC of the W-stage instruction, used for the write trace.
REQ-018 The block SHALL have port w_valid, output, 1 bit, meaning the W stage holds a real instruction.
REQ-019 The block SHALL have port w_retired, output, 32 bits, the count of instructions retired.

Function
REQ-020 The W-stage register update priority SHALL be, at each rising edge of clk: reset, then flush, then stall, then capture.
REQ-021 On capture, the block SHALL register the M-stage values, so that M-stage values appear on the W outputs exactly 1 cycle later.
REQ-022 A bubble SHALL set w_valid=0, w_regwrite=0, w_a3=0, w_wd=0 and w_pc=RESET_PC.
REQ-023 On stall without flush, all W outputs and w_retired SHALL hold their values.
REQ-024 w_regwrite SHALL be captured as m_valid AND m_regwrite AND (m_a3 != 0), so that writes to $0 are suppressed.
REQ-025 When m_valid=0, capture SHALL load a bubble regardless of the other M inputs.
REQ-026 Write-data selection SHALL use: wdsel 0 gives m_alu_result; wdsel 1 gives the extended load data; wdsel 2 gives m_pc+8 modulo 2^32; wdsel 3 gives 0.
REQ-027 Load extraction SHALL be little-endian, with a = m_alu_result[1:0].
REQ-028 For LW, the data SHALL be the whole word and a SHALL be ignored.
REQ-029 For LH and LHU, the half-word SHALL be selected by a[1]: 0 gives bits [15:0], 1 gives bits [31:16]; a[0] SHALL be ignored.
REQ-030 For LB and LBU, the byte SHALL be selected by a: 0 gives bits [7:0], 1 gives [15:8], 2 gives [23:16], 3 gives [31:24].
REQ-031 LH and LB SHALL sign-extend to 32 bits; LHU and LBU SHALL zero-extend to 32 bits.
REQ-032 m_load_type values 5 to 7 SHALL be treated as LW.
REQ-033 w_retired SHALL increment by 1 on each capture with m_valid=1.
REQ-034 w_retired SHALL not change on a stall, a flush or a bubble capture.
REQ-035 w_retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-036 All outputs SHALL be driven directly from registers, with no combinational path from M inputs to W outputs.

Reset
REQ-037 While reset=1 at a clock edge, the W stage SHALL load a bubble and w_retired SHALL become 0.
REQ-038 Reset asserted mid-stall or mid-flush SHALL take priority.
REQ-039 An instruction present in M during reset SHALL be discarded and not counted in w_retired.
REQ-040 The outputs SHALL be defined as the reset values from the first edge with reset=1 onward.

Verification
REQ-041 Reset check: assert reset for 2 cycles with arbitrary M inputs, then release -> w_valid=0, w_regwrite=0, w_a3=0, w_wd=0, w_pc=32'h3000, w_retired=0.
REQ-042 LB sign and LBU zero extension: m_mem_rdata=32'h80FF_7F01, alu=32'h0000_0002, LB, wdsel 1, a3=5 -> next cycle w_wd=32'hFFFF_FFFF, w_a3=5, w_regwrite=1; the same with LBU -> w_wd=32'h0000_00FF.
REQ-043 LH and jal write data: LH at addr ...2 with rdata 32'h8001_1234 -> w_wd=32'hFFFF_8001; wdsel 2 with m_pc=32'h0000_3010, a3=31 -> w_wd=32'h0000_3018.
REQ-044 $0 suppression and stall hold: m_regwrite=1 with a3=0 -> w_regwrite=0 and w_valid=1; stall for 3 cycles while the M inputs change -> all W outputs and w_retired unchanged.
REQ-045 Flush plus stall in the same cycle: flush=1 and stall=1 -> bubble loaded and w_retired unchanged.
REQ-046 Retire counter wrap: force 32'hFFFF_FFFF retires, then one more valid capture -> w_retired=0.
